tt_pin_bist: RTL and testbench

Self-test harness for the far side of the standard 8-in/8-out user-project pin interface. It drives pseudo-random stimulus onto a user module's ui_in bus and compacts that module's uo_out responses into a 16-bit signature. At the end of a run it compares the signature against a programmed golden value. It sits beside the tt_um_* user design in the wrapper and lets silicon bring-up run without an external pattern generator.

---
 rtl/tt_pin_bist.sv | 134 +++++++++++++
 tb/tb_tt_pin_bist.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_pin_bist.sv
// rtl/tt_pin_bist.sv - LFSR stimulus / MISR signature self-test harness for an 8-in/8-out user design
module tt_pin_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned SETTLE      = 2,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        start,
  input  logic [15:0] expected_sig,
  input  logic [7:0]  dut_uo_out,
  output logic [7:0]  stim_ui_in,
  output logic        dut_rst_n,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {IDLE, DRST, APPLY, DONE} state_t;

  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [15:0] VEC_LAST = 16'(NUM_VECTORS - 1);
  localparam logic [7:0]  SETTLE_V = 8'(SETTLE);

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] misr_q, misr_d;
  logic [15:0] vcnt_q, vcnt_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [7:0]  stim_d;
  logic        dut_rst_n_d, busy_d, done_d, pass_d;
  logic [7:0]  lfsr_step;
  logic [15:0] misr_step;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR; x^16+x^15+x^13+x^4+1 MISR
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign misr_step = {misr_q[14:0], misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3]}
                     ^ {8'h00, dut_uo_out};

  assign signature = misr_q;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    vcnt_d      = vcnt_q;
    settle_d    = settle_q;
    rcnt_d      = rcnt_q;
    stim_d      = stim_ui_in;
    dut_rst_n_d = dut_rst_n;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRST;
          lfsr_d      = SEED;
          misr_d      = 16'h0000;
          vcnt_d      = 16'h0000;
          rcnt_d      = 8'h00;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          dut_rst_n_d = 1'b0;
          stim_d      = 8'h00;
        end
      end
      DRST: begin
        if (rcnt_q == RST_LAST) begin
          state_d     = APPLY;
          dut_rst_n_d = 1'b1;
          stim_d      = lfsr_q;
          settle_d    = SETTLE_V;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      APPLY: begin
        if (settle_q == 8'h00) begin
          misr_d = misr_step;
          lfsr_d = lfsr_step;
          vcnt_d = vcnt_q + 16'd1;
          if (vcnt_q == VEC_LAST) begin
            // The verdict uses the post-capture signature so done and pass rise together.
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (misr_step == expected_sig);
          end else begin
            stim_d   = lfsr_step;
            settle_d = SETTLE_V;
          end
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      misr_q     <= 16'h0000;
      vcnt_q     <= 16'h0000;
      settle_q   <= 8'h00;
      rcnt_q     <= 8'h00;
      stim_ui_in <= 8'h00;
      dut_rst_n  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else if (ena) begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      misr_q     <= misr_d;
      vcnt_q     <= vcnt_d;
      settle_q   <= settle_d;
      rcnt_q     <= rcnt_d;
      stim_ui_in <= stim_d;
      dut_rst_n  <= dut_rst_n_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

endmodule

// File: tb/tb_tt_pin_bist.sv
// tb/tb_tt_pin_bist.sv - scoreboard bench for tt_pin_bist
module tb_tt_pin_bist;
  localparam int NV = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] exp_sig = 16'h0000;
  logic [15:0] exp2 = 16'h0000;
  logic        uo_mode = 1'b0;
  logic [7:0]  uo;
  logic [7:0]  uo2 = 8'h01;
  logic [7:0]  stim, stim2;
  logic        drst, drst2, busy, busy2, done, done2, pass, pass2;
  logic [15:0] sig, sig2;

  int checks = 0;
  int failures = 0;
  logic [15:0] sig_q[$];
  logic [7:0]  stim_q[$];

  // Stand-in user design: a fixed transform of its inputs, or silent.
  assign uo = uo_mode ? (stim ^ 8'h3C) : 8'h00;

  always #5 clk = ~clk;

  tt_pin_bist dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .expected_sig(exp_sig),
    .dut_uo_out(uo), .stim_ui_in(stim), .dut_rst_n(drst), .busy(busy),
    .done(done), .pass(pass), .signature(sig)
  );

  tt_pin_bist #(.NUM_VECTORS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .expected_sig(exp2),
    .dut_uo_out(uo2), .stim_ui_in(stim2), .dut_rst_n(drst2), .busy(busy2),
    .done(done2), .pass(pass2), .signature(sig2)
  );

  function automatic logic [7:0] lfsr_at(int n);
    logic [7:0] l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic logic [15:0] model_sig(bit mode, int n);
    logic [15:0] m = 16'h0000;
    logic [7:0]  l = 8'hA5;
    logic [7:0]  u;
    for (int i = 0; i < n; i++) begin
      u = mode ? (l ^ 8'h3C) : 8'h00;
      m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {8'h00, u};
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return m;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stim !== 8'h00 || drst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || sig !== 16'h0000) begin
      failures++;
      $display("FAIL reset: stim=%h drst=%b busy=%b done=%b pass=%b sig=%h, need 00 1 0 0 0 0000",
               stim, drst, busy, done, pass, sig);
    end
    checks++;
    if (drst2 !== 1'b1 || busy2 !== 1'b0 || sig2 !== 16'h0000) begin
      failures++;
      $display("FAIL reset_dut2: drst=%b busy=%b sig=%h, need 1 0 0000", drst2, busy2, sig2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stimulus();
    logic [7:0]  l = 8'hA5;
    logic [7:0]  e;
    logic [15:0] s;
    uo_mode = 1'b1;
    exp_sig = model_sig(1'b1, NV);
    sig_q.push_back(exp_sig);
    for (int v = 0; v < NV; v++) begin
      repeat (3) stim_q.push_back(l);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    pulse_start();
    checks++;
    if (drst !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_edge: drst=%b busy=%b done=%b, need 0 1 0", drst, busy, done);
    end
    for (int j = 1; j < 4; j++) begin
      @(posedge clk); #1;
      checks++;
      if (drst !== 1'b0) begin
        failures++;
        $display("FAIL drst_low edge%0d: drst=%b, need 0", j, drst);
      end
    end
    for (int j = 4; j < 772; j++) begin
      @(posedge clk); #1;
      e = stim_q.pop_front();
      checks++;
      if (stim !== e || busy !== 1'b1 || drst !== 1'b1) begin
        failures++;
        $display("FAIL stim edge%0d: stim=%h busy=%b drst=%b, need %h 1 1", j, stim, busy, drst, e);
      end
    end
    @(posedge clk); #1;
    s = sig_q.pop_front();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || sig !== s) begin
      failures++;
      $display("FAIL stim_done: done=%b busy=%b pass=%b sig=%h, need 1 0 1 %h", done, busy, pass, sig, s);
    end
  endtask

  task automatic test_two_vectors();
    int n;
    logic [15:0] s;
    for (int k = 0; k < 2; k++) begin
      exp2 = (k == 0) ? 16'h0003 : 16'h0004;
      sig_q.push_back(16'h0003);
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      n = 1;
      checks++;
      if (done2 !== 1'b0 || busy2 !== 1'b1) begin
        failures++;
        $display("FAIL two_start run%0d: done=%b busy=%b, need 0 1", k, done2, busy2);
      end
      while (done2 !== 1'b1 && n < 40) begin
        @(posedge clk); #1;
        n++;
        if (n == 8) begin
          checks++;
          if (sig2 !== 16'h0001) begin
            failures++;
            $display("FAIL two_first_capture run%0d: sig=%h, need 0001", k, sig2);
          end
        end
      end
      s = sig_q.pop_front();
      checks++;
      if (n !== 11 || done2 !== 1'b1) begin
        failures++;
        $display("FAIL two_latency run%0d: edges=%0d done=%b, need 11 1", k, n, done2);
      end
      checks++;
      if (sig2 !== s || pass2 !== (k == 0)) begin
        failures++;
        $display("FAIL two_result run%0d: sig=%h pass=%b, need %h %b", k, sig2, pass2, s, (k == 0));
      end
    end
  endtask

  task automatic test_zero_response();
    int n;
    bit nonzero = 1'b0;
    logic [15:0] s;
    uo_mode = 1'b0;
    exp_sig = 16'h0000;
    sig_q.push_back(model_sig(1'b0, NV));
    pulse_start();
    n = 1;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (sig !== 16'h0000) nonzero = 1'b1;
    end
    s = sig_q.pop_front();
    checks++;
    if (n !== 773 || done !== 1'b1) begin
      failures++;
      $display("FAIL zero_latency: edges=%0d done=%b, need 773 1", n, done);
    end
    checks++;
    if (nonzero || sig !== s || pass !== 1'b1) begin
      failures++;
      $display("FAIL zero_result: nonzero_seen=%b sig=%h pass=%b, need 0 %h 1", nonzero, sig, pass, s);
    end
  endtask

  task automatic test_start_and_ena();
    int n;
    logic [15:0] s;
    uo_mode = 1'b1;
    exp_sig = model_sig(1'b1, NV);
    sig_q.push_back(exp_sig);
    pulse_start();
    for (int j = 1; j <= 50; j++) begin
      @(posedge clk); #1;
    end
    pulse_start();
    for (int j = 52; j <= 60; j++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (stim !== lfsr_at(18) || busy !== 1'b1 || drst !== 1'b1) begin
      failures++;
      $display("FAIL start_ignored: stim=%h busy=%b drst=%b, need %h 1 1", stim, busy, drst, lfsr_at(18));
    end
    for (int j = 61; j <= 100; j++) begin
      @(posedge clk); #1;
    end
    ena = 1'b0;
    for (int f = 0; f < 10; f++) begin
      @(posedge clk); #1;
      checks++;
      if (stim !== lfsr_at(32) || sig !== model_sig(1'b1, 32) || busy !== 1'b1 || done !== 1'b0 || drst !== 1'b1) begin
        failures++;
        $display("FAIL ena_freeze cyc%0d: stim=%h sig=%h busy=%b done=%b drst=%b, need %h %h 1 0 1",
                 f, stim, sig, busy, done, drst, lfsr_at(32), model_sig(1'b1, 32));
      end
    end
    ena = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    s = sig_q.pop_front();
    checks++;
    if (n !== 672 || done !== 1'b1) begin
      failures++;
      $display("FAIL ena_latency: edges_after_freeze=%0d done=%b, need 672 1", n, done);
    end
    checks++;
    if (sig !== s || pass !== 1'b1) begin
      failures++;
      $display("FAIL ena_result: sig=%h pass=%b, need %h 1", sig, pass, s);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic [15:0] s;
    uo_mode = 1'b1;
    exp_sig = model_sig(1'b1, NV);
    pulse_start();
    for (int j = 1; j <= 300; j++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sig !== model_sig(1'b1, 98)) begin
      failures++;
      $display("FAIL pre_abort_sig: sig=%h, need %h", sig, model_sig(1'b1, 98));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (stim !== 8'h00 || drst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || sig !== 16'h0000) begin
      failures++;
      $display("FAIL async_abort: stim=%h drst=%b busy=%b done=%b pass=%b sig=%h, need 00 1 0 0 0 0000",
               stim, drst, busy, done, pass, sig);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    uo_mode = 1'b0;
    exp_sig = 16'h0000;
    sig_q.push_back(model_sig(1'b0, NV));
    pulse_start();
    n = 1;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    s = sig_q.pop_front();
    checks++;
    if (n !== 773 || sig !== s || pass !== 1'b1) begin
      failures++;
      $display("FAIL rerun_after_abort: edges=%0d sig=%h pass=%b, need 773 %h 1", n, sig, pass, s);
    end
  endtask

  initial begin
    test_reset();
    test_stimulus();
    test_two_vectors();
    test_zero_response();
    test_start_and_ena();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
